pipeline_scoreboard: RTL

Parametrised hazard and forwarding controller that replaces the fixed two-source, three-stage hazard detection and forwarding pair in the ARM pipeline. It tracks every in-flight register write in a shift-register scoreboard, one slot per post-decode stage. For each decode-stage source operand it decides whether to stall, or which later stage to forward from. It sits beside the ID stage: it drives the IF/ID freeze and the EXE operand-mux selects, and it inserts bubbles into the ID/EXE register.

---
 rtl/pipeline_scoreboard.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipeline_scoreboard.sv
// Scoreboard-based hazard/forwarding controller: one slot per post-decode stage.
// Optional counters stall_cycles/load_use_cycles when PIPELINE_SCOREBOARD_STATS_EN is defined.

module pipeline_scoreboard_src #(
    parameter int ADDR_W           = 4,
    parameter int DEPTH            = 3,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SEL_W            = $clog2(DEPTH)
) (
    input  logic                           frwrd_en,
    input  logic                           src_used,
    input  logic [ADDR_W-1:0]              src,
    input  logic [DEPTH-1:0]               slot_vld,
    input  logic [DEPTH-1:0]               slot_wb,
    input  logic [DEPTH-1:0]               slot_mem,
    input  logic [DEPTH-1:0][ADDR_W-1:0]   slot_dest,
    output logic                           hazard,
    output logic                           load_haz,
    output logic [SEL_W-1:0]               sel
);
    // Scan oldest to youngest so the youngest matching producer has the final say.
    always_comb begin
        hazard   = 1'b0;
        load_haz = 1'b0;
        sel      = '0;
        for (int j = DEPTH-1; j >= 0; j--) begin
            if (src_used && slot_vld[j] && slot_wb[j] && slot_dest[j] == src) begin
                hazard   = 1'b0;
                load_haz = 1'b0;
                sel      = '0;
                if (j < DEPTH-1) begin
                    if (!frwrd_en) begin
                        hazard = 1'b1;
                    end else if (slot_mem[j] && (j + 1) < LOAD_READY_STAGE) begin
                        hazard   = 1'b1;
                        load_haz = 1'b1;
                    end else begin
                        sel = SEL_W'(j + 1);
                    end
                end
            end
        end
    end
endmodule

module pipeline_scoreboard #(
    parameter int ADDR_W           = 4,
    parameter int NSRC             = 2,
    parameter int DEPTH            = 3,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SEL_W            = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frwrd_en,
    input  logic                     issue_valid,
    input  logic                     issue_wb_en,
    input  logic                     issue_mem_r,
    input  logic [ADDR_W-1:0]        issue_dest,
    input  logic [NSRC*ADDR_W-1:0]   src_addr,
    input  logic [NSRC-1:0]          src_used,
    input  logic                     flush,
    output logic                     stall,
    output logic [NSRC*SEL_W-1:0]    fwd_sel
`ifdef PIPELINE_SCOREBOARD_STATS_EN
    ,
    output logic [15:0]              stall_cycles,
    output logic [15:0]              load_use_cycles
`endif
);
    logic [DEPTH-1:0]             vld_pipe;
    logic [DEPTH-1:0]             slot_wb;
    logic [DEPTH-1:0]             slot_mem;
    logic [DEPTH-1:0][ADDR_W-1:0] slot_dest;

    logic [NSRC-1:0]              hazard;
    logic [NSRC-1:0]              load_haz;
    logic [NSRC-1:0][SEL_W-1:0]   sel_nxt;
    logic [NSRC-1:0][SEL_W-1:0]   fwd_sel_q;
    logic                         issue;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        pipeline_scoreboard_src #(
            .ADDR_W(ADDR_W), .DEPTH(DEPTH),
            .LOAD_READY_STAGE(LOAD_READY_STAGE), .SEL_W(SEL_W)
        ) u_src (
            .frwrd_en (frwrd_en),
            .src_used (src_used[g]),
            .src      (src_addr[g*ADDR_W +: ADDR_W]),
            .slot_vld (vld_pipe),
            .slot_wb  (slot_wb),
            .slot_mem (slot_mem),
            .slot_dest(slot_dest),
            .hazard   (hazard[g]),
            .load_haz (load_haz[g]),
            .sel      (sel_nxt[g])
        );
    end

    // Flush dominates a hazard: the killed instruction never needs its operands.
    assign stall   = issue_valid & ~flush & (|hazard);
    assign issue   = issue_valid & ~stall & ~flush;
    assign fwd_sel = fwd_sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            slot_wb   <= '0;
            slot_mem  <= '0;
            slot_dest <= '0;
            fwd_sel_q <= '0;
        end else begin
            for (int j = DEPTH-1; j > 0; j--) begin
                vld_pipe[j]  <= vld_pipe[j-1];
                slot_wb[j]   <= slot_wb[j-1];
                slot_mem[j]  <= slot_mem[j-1];
                slot_dest[j] <= slot_dest[j-1];
            end
            vld_pipe[0]  <= issue;
            slot_wb[0]   <= issue_wb_en;
            slot_mem[0]  <= issue_mem_r;
            slot_dest[0] <= issue_dest;
            fwd_sel_q    <= issue ? sel_nxt : '0;
        end
    end

`ifdef PIPELINE_SCOREBOARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles    <= '0;
            load_use_cycles <= '0;
        end else begin
            if (stall && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (stall && frwrd_en && (|load_haz) && load_use_cycles != 16'hFFFF)
                load_use_cycles <= load_use_cycles + 16'd1;
        end
    end
`endif
endmodule
